// File: rtl/br_flow_seq_checker.sv
// Pop-end receiver for an incrementing ready/valid stream: drives pseudo-random
// backpressure, checks each accepted word against a running sequence, and flags producer stability violations.
module br_flow_seq_checker #(
  parameter int Width      = 8,
  parameter int CountWidth = 16,
  parameter int StallBits  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [Width-1:0]      data,
  output logic                  ready,
  output logic [CountWidth-1:0] item_count,
  output logic [CountWidth-1:0] mismatch_count,
  output logic                  data_error,
  output logic                  protocol_error,
  output logic [Width-1:0]      first_expected,
  output logic [Width-1:0]      first_actual
);

  // Handshake: a beat is valid && ready at a clk edge; ready is registered,
  // and once valid is raised the producer must hold valid and data until the beat.

  localparam logic [15:0]           LfsrSeed = 16'hACE1;
  localparam logic [Width-1:0]      DataOne  = Width'(1);
  localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [Width-1:0] expected;
  logic [Width-1:0] prev_data;
  logic             stall_armed;
  logic             stall_hit;
  logic             ready_next;
  logic             beat;
  logic             mismatch;
  logic             protocol_violation;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  assign lfsr_next = enable ? {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]} : lfsr;

  if (StallBits == 0) begin : g_no_stall
    assign stall_hit = 1'b0;
  end else begin : g_stall
    assign stall_hit = (lfsr_next[StallBits-1:0] == '0);
  end

  assign ready_next         = enable && !stall_hit;
  assign beat               = valid && ready;
  assign mismatch           = beat && (data != expected);
  assign protocol_violation = stall_armed && (!valid || (data != prev_data));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= LfsrSeed;
      ready       <= 1'b0;
      stall_armed <= 1'b0;
      prev_data   <= '0;
    end else if (clear) begin
      lfsr        <= LfsrSeed;
      ready       <= 1'b0;
      stall_armed <= 1'b0;
      prev_data   <= '0;
    end else begin
      lfsr        <= lfsr_next;
      ready       <= ready_next;
      stall_armed <= valid && !ready;
      prev_data   <= data;
    end
  end

  // The expected value advances on every beat, so one bad word is counted once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected   <= '0;
      item_count <= '0;
    end else if (clear) begin
      expected   <= '0;
      item_count <= '0;
    end else if (beat) begin
      expected <= expected + DataOne;
      if (item_count != '1) begin
        item_count <= item_count + CountOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_count <= '0;
      data_error     <= 1'b0;
      first_expected <= '0;
      first_actual   <= '0;
    end else if (clear) begin
      mismatch_count <= '0;
      data_error     <= 1'b0;
      first_expected <= '0;
      first_actual   <= '0;
    end else if (mismatch) begin
      data_error <= 1'b1;
      if (mismatch_count != '1) begin
        mismatch_count <= mismatch_count + CountOne;
      end
      if (!data_error) begin
        first_expected <= expected;
        first_actual   <= data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_error <= 1'b0;
    end else if (clear) begin
      protocol_error <= 1'b0;
    end else if (protocol_violation) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_br_flow_seq_checker.sv
// Bench for br_flow_seq_checker: deterministic vectors on StallBits=0 instances,
// randomized producers on a StallBits=2 instance against a behavioural model.
module tb_br_flow_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       valid_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       valid_b = 1'b0;
  logic [7:0] data_b = 8'h00;

  logic        a_ready, a_derr, a_perr;
  logic [15:0] a_items, a_mm;
  logic [7:0]  a_fe, a_fa;
  logic        b_ready, b_derr, b_perr;
  logic [15:0] b_items, b_mm;
  logic [7:0]  b_fe, b_fa;
  logic        c_ready, c_derr, c_perr;
  logic [3:0]  c_items, c_mm;
  logic [7:0]  c_fe, c_fa;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  br_flow_seq_checker #(.Width(8), .CountWidth(16), .StallBits(0)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .valid(valid_a), .data(data_a),
    .ready(a_ready), .item_count(a_items), .mismatch_count(a_mm), .data_error(a_derr),
    .protocol_error(a_perr), .first_expected(a_fe), .first_actual(a_fa));

  br_flow_seq_checker #(.Width(8), .CountWidth(16), .StallBits(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .valid(valid_b), .data(data_b),
    .ready(b_ready), .item_count(b_items), .mismatch_count(b_mm), .data_error(b_derr),
    .protocol_error(b_perr), .first_expected(b_fe), .first_actual(b_fa));

  br_flow_seq_checker #(.Width(8), .CountWidth(4), .StallBits(0)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .valid(valid_a), .data(data_a),
    .ready(c_ready), .item_count(c_items), .mismatch_count(c_mm), .data_error(c_derr),
    .protocol_error(c_perr), .first_expected(c_fe), .first_actual(c_fa));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // ---------------- reference model for dut_b ----------------
  int m_lfsr = 'hACE1;
  int m_items = 0, m_mm = 0, m_exp = 0, m_fe = 0, m_fa = 0, m_prev = 0;
  bit m_ready = 0, m_derr = 0, m_perr = 0, m_armed = 0;

  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (fb << 15);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      m_lfsr = 'hACE1; m_ready = 0; m_items = 0; m_mm = 0; m_exp = 0;
      m_derr = 0; m_perr = 0; m_armed = 0; m_fe = 0; m_fa = 0;
    end else begin
      if (m_armed && (!valid_b || int'(data_b) != m_prev)) m_perr = 1;
      if (valid_b && m_ready) begin
        if (m_items < 65535) m_items++;
        if (int'(data_b) != m_exp) begin
          if (m_mm < 65535) m_mm++;
          if (!m_derr) begin m_fe = m_exp; m_fa = int'(data_b); end
          m_derr = 1;
        end
        m_exp = (m_exp + 1) % 256;
      end
      m_armed = valid_b && !m_ready;
      if (enable) m_lfsr = lfsr_step(m_lfsr);
      m_ready = enable && (m_lfsr % 4 != 0);
    end
    m_prev = int'(data_b);
  end

  always @(negedge clk) begin
    check("b_model", {b_ready, b_items, b_mm, b_derr, b_perr, b_fe, b_fa},
          {m_ready, 16'(m_items), 16'(m_mm), m_derr, m_perr, 8'(m_fe), 8'(m_fa)});
  end

  // ---------------- vector table for dut_a / dut_c ----------------
  typedef struct {
    logic        clr, en, v;
    logic [7:0]  d;
    logic        rdy;
    logic [15:0] items, mm;
    logic        derr, perr;
    logic [7:0]  fe, fa;
  } vec_t;

  vec_t tv[24];

  function automatic vec_t mk(input int clr, input int en, input int v, input int d, input int rdy,
                              input int items, input int mm, input int derr, input int perr,
                              input int fe, input int fa);
    vec_t r;
    r.clr = clr[0]; r.en = en[0]; r.v = v[0]; r.d = d[7:0]; r.rdy = rdy[0];
    r.items = items[15:0]; r.mm = mm[15:0]; r.derr = derr[0]; r.perr = perr[0];
    r.fe = fe[7:0]; r.fa = fa[7:0];
    return r;
  endfunction

  function automatic logic [3:0] sat15(input logic [15:0] x);
    return (x > 16'd15) ? 4'hF : x[3:0];
  endfunction

  task automatic burst_a(input logic [7:0] start, input int n, input bit chk_ready);
    int w;
    bit beat;
    logic [7:0] word;
    w = 0; word = start; valid_a = 1'b1; data_a = start;
    for (int cyc = 0; cyc < 4 * n + 8 && w < n; cyc++) begin
      beat = a_ready;
      @(negedge clk);
      if (chk_ready) check("a_ready_hold", a_ready, 1);
      if (beat) begin w++; word++; data_a = word; end
    end
    valid_a = 1'b0;
    check("a_burst_len", w, n);
  endtask

  task automatic run_b(input int max_cyc, input int n_words, input int gap_pct, input int bad_pct,
                       input bit wild, output int w, output int stalls, output int cycles,
                       output int bad_sent);
    logic [7:0] word;
    bit beat;
    w = 0; stalls = 0; cycles = 0; bad_sent = 0; word = 8'h00; valid_b = 1'b0;
    for (int cyc = 0; cyc < max_cyc && w < n_words; cyc++) begin
      if (wild) begin
        valid_b = 1'($urandom_range(0, 1));
        data_b  = 8'($urandom_range(0, 3));
        enable  = ($urandom_range(0, 7) != 0);
      end else if (!valid_b && $urandom_range(0, 99) >= gap_pct) begin
        valid_b = 1'b1;
        if ($urandom_range(0, 99) < bad_pct) begin
          data_b = ~word;
          bad_sent++;
        end else begin
          data_b = word;
        end
      end
      beat = valid_b && b_ready;
      if (!b_ready) stalls++;
      cycles++;
      @(negedge clk);
      if (beat) begin w++; word++; if (!wild) valid_b = 1'b0; end
    end
    valid_b = 1'b0;
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got still running expected finished");
    report();
    $finish;
  end

  initial begin
    int w, stalls, cycles, bad_sent;
    logic [3:0] c_exp_items, c_exp_mm;

    //              clr en v  d      rdy items mm derr perr fe  fa
    tv[0]  = mk(1, 1, 1, 'h2C, 0, 0,  0, 0, 0, 0, 0);
    tv[1]  = mk(0, 1, 0, 'h00, 1, 0,  0, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, 1, 'h00, 1, 1,  0, 0, 0, 0, 0);
    tv[3]  = mk(0, 1, 1, 'h01, 1, 2,  0, 0, 0, 0, 0);
    tv[4]  = mk(0, 1, 1, 'h02, 1, 3,  0, 0, 0, 0, 0);
    tv[5]  = mk(0, 1, 1, 'h03, 1, 4,  0, 0, 0, 0, 0);
    tv[6]  = mk(0, 1, 1, 'h04, 1, 5,  0, 0, 0, 0, 0);
    tv[7]  = mk(0, 1, 1, 'h99, 1, 6,  1, 1, 0, 5, 'h99);
    tv[8]  = mk(0, 1, 1, 'h06, 1, 7,  1, 1, 0, 5, 'h99);
    tv[9]  = mk(0, 1, 1, 'h08, 1, 8,  2, 1, 0, 5, 'h99);
    tv[10] = mk(0, 1, 1, 'h08, 1, 9,  2, 1, 0, 5, 'h99);
    tv[11] = mk(0, 0, 1, 'h09, 0, 10, 2, 1, 0, 5, 'h99);
    tv[12] = mk(0, 0, 1, 'h0A, 0, 10, 2, 1, 0, 5, 'h99);
    tv[13] = mk(0, 0, 0, 'h0A, 0, 10, 2, 1, 1, 5, 'h99);
    tv[14] = mk(0, 1, 0, 'h00, 1, 10, 2, 1, 1, 5, 'h99);
    tv[15] = mk(1, 1, 0, 'h00, 0, 0,  0, 0, 0, 0, 0);
    tv[16] = mk(0, 1, 0, 'h00, 1, 0,  0, 0, 0, 0, 0);
    tv[17] = mk(0, 1, 1, 'h00, 1, 1,  0, 0, 0, 0, 0);
    tv[18] = mk(0, 0, 0, 'h00, 0, 1,  0, 0, 0, 0, 0);
    tv[19] = mk(0, 0, 1, 'h10, 0, 1,  0, 0, 0, 0, 0);
    tv[20] = mk(0, 0, 1, 'h11, 0, 1,  0, 0, 1, 0, 0);
    tv[21] = mk(0, 1, 1, 'h11, 1, 1,  0, 0, 1, 0, 0);
    tv[22] = mk(0, 1, 1, 'h01, 1, 2,  0, 0, 1, 0, 0);
    tv[23] = mk(0, 1, 0, 'h00, 1, 2,  0, 0, 1, 0, 0);

    // clock/reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a", {a_ready, a_items, a_mm, a_derr, a_perr, a_fe, a_fa}, 0);
    check("rst_c", {c_ready, c_items, c_mm, c_derr, c_perr, c_fe, c_fa}, 0);
    rst = 1'b0;
    enable = 1'b1;

    // 300 words with valid held high; counter wraps through 255 -> 0
    burst_a(8'h00, 300, 1'b1);
    check("a_items_300", a_items, 300);
    check("a_mm_300", a_mm, 0);
    check("a_derr_300", a_derr, 0);
    check("c_items_sat", c_items, 4'hF);
    check("c_mm_300", c_mm, 0);

    for (int i = 0; i < 24; i++) begin
      clear = tv[i].clr; enable = tv[i].en; valid_a = tv[i].v; data_a = tv[i].d;
      @(negedge clk);
      check($sformatf("tv%0d_a", i), {a_ready, a_items, a_mm, a_derr, a_perr, a_fe, a_fa},
            {tv[i].rdy, tv[i].items, tv[i].mm, tv[i].derr, tv[i].perr, tv[i].fe, tv[i].fa});
      c_exp_items = sat15(tv[i].items);
      c_exp_mm    = sat15(tv[i].mm);
      check($sformatf("tv%0d_c", i), {c_ready, c_items, c_mm, c_derr, c_perr, c_fe, c_fa},
            {tv[i].rdy, c_exp_items, c_exp_mm, tv[i].derr, tv[i].perr, tv[i].fe, tv[i].fa});
    end
    clear = 1'b0; enable = 1'b1; valid_a = 1'b0;

    // reset asserted mid-burst
    burst_a(8'h02, 5, 1'b1);
    valid_a = 1'b1; data_a = 8'h07;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ready", a_ready, 0);
    check("rst_mid_items", a_items, 0);
    check("rst_mid_c_items", c_items, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_items", a_items, 0);
    check("rst_hold_perr", a_perr, 0);
    rst = 1'b0; valid_a = 1'b0;
    burst_a(8'h00, 10, 1'b0);
    check("post_rst_items", a_items, 10);
    check("post_rst_errs", {a_mm, a_derr, a_perr}, 0);

    // randomized producers against the reference model
    clear = 1'b1; @(negedge clk); clear = 1'b0; enable = 1'b1;
    run_b(6000, 1000, 10, 0, 1'b0, w, stalls, cycles, bad_sent);
    check("b_words_1000", w, 1000);
    check("b_items_1000", b_items, 1000);
    check("b_errs_1000", {b_mm, b_derr, b_perr}, 0);
    n_cmp++;
    if (stalls * 100 < cycles * 15 || stalls * 100 > cycles * 35) begin
      n_bad++;
      $display("FAIL b_stall_ratio: got %0d stalls in %0d cycles expected about 25%%", stalls, cycles);
    end

    clear = 1'b1; @(negedge clk); clear = 1'b0;
    run_b(3000, 300, 20, 8, 1'b0, w, stalls, cycles, bad_sent);
    check("b_words_300", w, 300);
    check("b_items_300", b_items, 300);
    check("b_mm_injected", b_mm, bad_sent);

    clear = 1'b1; @(negedge clk); clear = 1'b0;
    run_b(400, 1000000, 0, 0, 1'b1, w, stalls, cycles, bad_sent);
    enable = 1'b1;
    @(negedge clk);
    check("b_wild_perr", b_perr, 1);

    report();
    $finish;
  end

endmodule
